// File: rtl/fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit
//
// Front-end fetch stage sitting directly upstream of the decoder. It walks the
// program counter, issues at most one word-aligned request per cycle to a
// synchronous instruction memory, and parks each returned word together with
// its PC in a small FIFO. The decoder pulls from the FIFO head over a
// valid/ready handshake. A redirect from branch resolution flushes everything
// and restarts fetch at the new target.
//
// Parameters
//   RESET_PC     PC fetched first after reset
//   QUEUE_DEPTH  instruction queue entries (power of two, >= 2)
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             synchronous active-high reset (overrides redirect)
//   imem_req        fetch request this cycle
//   imem_addr       fetch address, bits [1:0] always 0
//   imem_rdata      instruction word, valid the cycle after a request
//   redirect_valid  flush the queue and restart fetch at redirect_pc
//   redirect_pc     new fetch PC, bits [1:0] ignored
//   out_valid       out_instr/out_pc hold a valid entry
//   out_ready       decoder accepts the head entry
//   out_instr       head instruction word
//   out_pc          PC of the head instruction
//   queue_count     entries currently held
// ---------------------------------------------------------------------------
module fetch_queue_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic                           imem_req,
    output logic [31:0]                    imem_addr,
    input  logic [31:0]                    imem_rdata,
    input  logic                           redirect_valid,
    input  logic [31:0]                    redirect_pc,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_instr,
    output logic [31:0]                    out_pc,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    // PCs are always word aligned, so only bits [31:2] are stored. A 30-bit
    // increment then gives the required 32-bit wrap (FFFF_FFFC + 4 = 0).
    logic [29:0]     fetch_pc_reg;
    logic [29:0]     fetch_pc_next;
    logic            inflight_reg;
    logic            inflight_next;
    logic [29:0]     inflight_pc_reg;
    logic [29:0]     inflight_pc_next;
    logic [PW-1:0]   head_reg;
    logic [PW-1:0]   head_next;
    logic [PW-1:0]   tail_reg;
    logic [PW-1:0]   tail_next;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;

    // Queue storage: instruction word and word-address of its PC.
    logic [31:0]     instr_mem [QUEUE_DEPTH];
    logic [29:0]     pc_mem    [QUEUE_DEPTH];

    logic            issue;
    logic            fill;
    logic            fire;
    logic [CW:0]     credit_used;
    logic [QUEUE_DEPTH-1:0] wr_en;

    // The two low bits of the redirect target carry no information.
    logic            unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // -----------------------------------------------------------------------
    // Issue: an outstanding request already owns a queue slot, so the credit
    // check counts it. This is what makes a queue overflow impossible.
    // -----------------------------------------------------------------------
    assign credit_used = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
    assign issue       = !rst && !redirect_valid &&
                         (credit_used < (CW+1)'(QUEUE_DEPTH));

    assign imem_req    = issue;
    assign imem_addr   = {fetch_pc_reg, 2'b00};

    // A response arriving in a redirect cycle belongs to the old path.
    assign fill        = !rst && !redirect_valid && inflight_reg;

    // -----------------------------------------------------------------------
    // Drain side. Redirect (and reset) hide the head so nothing is handed to
    // the decoder in a cycle whose queue contents are being discarded.
    // -----------------------------------------------------------------------
    assign out_valid   = !rst && !redirect_valid && (count_reg != '0);
    assign fire        = out_valid && out_ready;
    assign out_instr   = instr_mem[head_reg];
    assign out_pc      = {pc_mem[head_reg], 2'b00};
    assign queue_count = count_reg;

    // -----------------------------------------------------------------------
    // Per-entry write enables: decode the tail pointer once per slot.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = fill && (tail_reg == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (wr_en[i]) begin
                instr_mem[i] <= imem_rdata;
                pc_mem[i]    <= inflight_pc_reg;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. Priority: reset (in the register block), redirect,
    // then normal issue/fill/drain.
    // -----------------------------------------------------------------------
    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        inflight_next    = 1'b0;
        inflight_pc_next = inflight_pc_reg;
        head_next        = head_reg;
        tail_next        = tail_reg;
        count_next       = count_reg;

        if (redirect_valid) begin
            fetch_pc_next = redirect_pc[31:2];
            head_next     = '0;
            tail_next     = '0;
            count_next    = '0;
        end else begin
            if (issue) begin
                inflight_next    = 1'b1;
                inflight_pc_next = fetch_pc_reg;
                fetch_pc_next    = fetch_pc_reg + 30'd1;
            end
            if (fill) begin
                tail_next = tail_reg + PW'(1);
            end
            if (fire) begin
                head_next = head_reg + PW'(1);
            end
            unique case ({fill, fire})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC[31:2];
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            inflight_reg    <= inflight_next;
            inflight_pc_reg <= inflight_pc_next;
            head_reg        <= head_next;
            tail_reg        <= tail_next;
            count_reg       <= count_next;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// Directed testbench for fetch_queue_unit. Instruction memory models return
// (address ^ 32'h5A00_0000) one cycle after each request, so instruction and
// PC values are distinguishable. A second instance with RESET_PC=FFFF_FFF8
// exercises PC wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch_queue_unit;

    localparam logic [31:0] K = 32'h5A00_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  queue_count;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_rdata;
    logic        w_redirect_valid = 1'b0;
    logic [31:0] w_redirect_pc    = 32'h0;
    logic        w_out_valid;
    logic        w_out_ready      = 1'b1;
    logic [31:0] w_out_instr;
    logic [31:0] w_out_pc;
    logic [2:0]  w_queue_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_queue_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .queue_count    (queue_count)
    );

    fetch_queue_unit #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(4)) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (w_imem_req),
        .imem_addr      (w_imem_addr),
        .imem_rdata     (w_imem_rdata),
        .redirect_valid (w_redirect_valid),
        .redirect_pc    (w_redirect_pc),
        .out_valid      (w_out_valid),
        .out_ready      (w_out_ready),
        .out_instr      (w_out_instr),
        .out_pc         (w_out_pc),
        .queue_count    (w_queue_count)
    );

    // Synchronous instruction memories.
    always @(posedge clk) begin
        if (imem_req)   imem_rdata   <= imem_addr ^ K;
        if (w_imem_req) w_imem_rdata <= w_imem_addr ^ K;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] wrap_exp [3];

    initial begin
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        repeat (3) step();
        check("rst_req",   32'(imem_req),    32'd0);
        check("rst_valid", 32'(out_valid),   32'd0);
        check("rst_count", 32'(queue_count), 32'd0);

        // Cycle 0
        rst = 1'b0;
        #1;
        check("c0_req",   32'(imem_req),  32'd1);
        check("c0_addr",  imem_addr,      32'h0);
        check("c0_valid", 32'(out_valid), 32'd0);
        // Cycle 1
        step();
        check("c1_req",   32'(imem_req),  32'd1);
        check("c1_addr",  imem_addr,      32'h4);
        check("c1_valid", 32'(out_valid), 32'd0);
        // Cycles 2..7: one instruction per cycle
        for (int c = 2; c <= 7; c++) begin
            step();
            check("stream_valid", 32'(out_valid),   32'd1);
            check("stream_pc",    out_pc,           32'(4 * (c - 2)));
            check("stream_instr", out_instr,        32'(4 * (c - 2)) ^ K);
            check("stream_count", 32'(queue_count), 32'd1);
            if (c <= 4) begin
                check("wrap_valid", 32'(w_out_valid), 32'd1);
                check("wrap_pc",    w_out_pc,         wrap_exp[c - 2]);
                check("wrap_instr", w_out_instr,      wrap_exp[c - 2] ^ K);
            end
        end

        // Cycle 8: stall the decoder
        step();
        out_ready = 1'b0;
        #1;
        check("stall_pc0",   out_pc,           32'h18);
        check("stall_cnt0",  32'(queue_count), 32'd1);
        for (int c = 9; c <= 17; c++) begin
            step();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_pc",    out_pc,         32'h18);
            check("stall_instr", out_instr,      32'h18 ^ K);
            if (c == 10) begin
                check("stall_cnt10", 32'(queue_count), 32'd3);
                check("stall_req10", 32'(imem_req),    32'd0);
            end
        end
        check("full_count", 32'(queue_count), 32'd4);
        check("full_req",   32'(imem_req),    32'd0);
        check("full_addr",  imem_addr,        32'h28);

        // Cycle 18: release, expect 0x18.. in order with no gap
        step();
        out_ready = 1'b1;
        #1;
        check("drain_count", 32'(queue_count), 32'd4);
        for (int i = 0; i <= 5; i++) begin
            if (i != 0) step();
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_pc",    out_pc,         32'h18 + 32'(4 * i));
            check("drain_instr", out_instr,      (32'h18 + 32'(4 * i)) ^ K);
        end

        // Cycle 24: stall again; cycle 25 holds 3 entries + 1 in flight
        step();
        out_ready = 1'b0;
        #1;
        check("s2_pc",    out_pc,           32'h30);
        check("s2_count", 32'(queue_count), 32'd2);
        step();
        check("s2_count3", 32'(queue_count), 32'd3);
        check("s2_req",    32'(imem_req),    32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        check("redir_valid", 32'(out_valid), 32'd0);
        check("redir_req",   32'(imem_req),  32'd0);
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        #1;
        check("redir1_count", 32'(queue_count), 32'd0);
        check("redir1_valid", 32'(out_valid),   32'd0);
        check("redir1_req",   32'(imem_req),    32'd1);
        check("redir1_addr",  imem_addr,        32'h100);
        step();
        check("redir2_valid", 32'(out_valid), 32'd0);
        check("redir2_addr",  imem_addr,      32'h104);
        step();
        check("redir3_valid", 32'(out_valid), 32'd1);
        check("redir3_pc",    out_pc,         32'h100);
        check("redir3_instr", out_instr,      32'h100 ^ K);
        step();
        check("redir4_pc",    out_pc,         32'h104);
        step();
        check("redir5_pc",    out_pc,         32'h108);

        // Cycle 31: redirect coinciding with a would-be handoff
        step();
        check("pre_fire_valid", 32'(out_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #1;
        check("rf_valid", 32'(out_valid), 32'd0);
        check("rf_req",   32'(imem_req),  32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("rf1_count", 32'(queue_count), 32'd0);
        check("rf1_valid", 32'(out_valid),   32'd0);
        check("rf1_addr",  imem_addr,        32'h200);
        step();
        check("rf2_valid", 32'(out_valid), 32'd0);
        step();
        check("rf3_valid", 32'(out_valid), 32'd1);
        check("rf3_pc",    out_pc,         32'h200);

        // Cycle 35: fill the queue, then reset together with redirect
        step();
        out_ready = 1'b0;
        #1;
        step();
        step();
        step();
        check("pre_rst_count", 32'(queue_count), 32'd4);
        check("pre_rst_pc",    out_pc,           32'h204);
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_req",   32'(imem_req),  32'd0);
        step();
        check("rst_next_count", 32'(queue_count), 32'd0);
        check("rst_next_valid", 32'(out_valid),   32'd0);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        #1;
        check("restart_req",  32'(imem_req), 32'd1);
        check("restart_addr", imem_addr,     32'h0);
        step();
        step();
        check("restart_valid", 32'(out_valid), 32'd1);
        check("restart_pc",    out_pc,         32'h0);
        step();
        check("restart_pc1",   out_pc,         32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Front-end instruction fetch stage directly upstream of the decoder. Generates the program counter, issues one word-aligned fetch per cycle to a synchronous instruction memory, and buffers returned instructions with their PCs in a small FIFO. Hands one instruction per cycle to decode over a valid/ready handshake. Flushes on a redirect from branch resolution.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- QUEUE_DEPTH, 4, instruction queue entries (power of two, ≥2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request this cycle
- imem_addr  out  32  fetch address, bits [1:0] always 0
- imem_rdata  in  32  instruction word, valid the cycle after a request
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch PC, bits [1:0] ignored (treated as 0)
- out_valid  out  1  out_instr/out_pc hold a valid entry
- out_ready  in  1  decoder accepts the head entry
- out_instr  out  32  head instruction word, fed to the decoder's instruction input
- out_pc  out  32  PC of head instruction
- queue_count  out  $clog2(QUEUE_DEPTH)+1  entries currently held

## Operation
- State: fetch_pc, inflight flag, inflight_pc, queue storage, head/tail pointers, count.
- Reset: fetch_pc=RESET_PC, inflight=0, count=0, head=tail=0. Outputs: imem_req=0, out_valid=0, queue_count=0, out_instr/out_pc don't-care.
- Issue: imem_req = !rst && !redirect_valid && (count + inflight < QUEUE_DEPTH); imem_addr = fetch_pc. On issue: inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (32-bit wrap, 32'hFFFF_FFFC+4=0), inflight<=1; otherwise inflight<=0.
- Fill: when inflight=1 and no redirect, write {imem_rdata, inflight_pc} at tail, tail+1 (mod depth).
- Drain: out_valid = (count!=0) && !redirect_valid; fire = out_valid && out_ready; head+1 on fire.
- count updates by +fill −fire; simultaneous fill and fire leaves count unchanged. Credit rule guarantees fill never hits a full queue; no overflow path exists.
- Redirect (highest priority): clear queue (head=tail=count=0), drop in-flight response (inflight<=0, rdata ignored), fetch_pc<={redirect_pc[31:2],2'b00}, no request and no fire that cycle.
- Redirect while queue empty and nothing in flight behaves identically.
- rst overrides redirect.

## Timing
- Cycle 0 = first cycle rst low: imem_req=1, imem_addr=RESET_PC.
- Cycle 1: imem_rdata valid for RESET_PC; written at end of cycle 1.
- Cycle 2: out_valid=1, out_pc=RESET_PC. Fetch-to-decode latency = 2 cycles.
- Steady state with out_ready held high: one instruction per cycle, consecutive PCs +4.
- With out_ready low: queue fills to QUEUE_DEPTH; imem_req drops once count+inflight=QUEUE_DEPTH; no word lost or duplicated.
- Redirect asserted in cycle N: first request to redirect_pc in N+1, its instruction at out_* in N+3.
- out_valid/out_instr/out_pc stable while out_valid=1 and out_ready=0, except on redirect.

## Test plan
- Reset, imem returns word = address, out_ready=1 -> out_valid first in cycle 2; out_pc/out_instr 0,4,8,... one per cycle, no gaps.
- out_ready=0 for 10 cycles -> queue_count reaches 4, imem_req low, fetch_pc=0x10; release ready -> 0x0..0xC drained in order, then 0x10 continues without gap or duplicate.
- redirect_valid one cycle with redirect_pc=0x103 while queue holds 3 entries and one in flight -> queue_count=0 next cycle, stale response discarded, next out_pc=0x100 three cycles after redirect.
- Redirect in same cycle as out_valid&&out_ready -> out_valid forced 0, no handoff, next out_pc = redirect target.
- Start RESET_PC=32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst mid-stream with full queue and redirect_valid=1 -> next cycle queue_count=0, out_valid=0, then restart at RESET_PC.
